// File: rtl/v_issue_queue_if.sv
// Handshake bundle of the vector issue queue: producer-side instruction intake
// and coprocessor-side issue/completion signals.
interface v_issue_queue_if;
  logic [31:0] instr_in;
  logic [31:0] xreg_in;
  logic        instr_valid;
  logic        instr_ready;
  logic [31:0] issue_instr;
  logic [31:0] issue_xreg;
  logic        issue_valid;
  logic        unit_done;

  modport master (
    output instr_in, xreg_in, instr_valid, unit_done,
    input  instr_ready, issue_instr, issue_xreg, issue_valid
  );

  modport slave (
    input  instr_in, xreg_in, instr_valid, unit_done,
    output instr_ready, issue_instr, issue_xreg, issue_valid
  );
endinterface

// File: rtl/v_issue_queue.sv
// Vector instruction FIFO and single-issue sequencer (IDLE/EXEC/RETIRE).
// Optional performance counters are enabled by defining V_IQ_PERF_EN.
module v_issue_queue #(
  parameter int DEPTH = 4,
  parameter int CW    = $clog2(DEPTH) + 1
) (
  input  logic          clk,
  input  logic          rst,
  v_issue_queue_if.slave iq,
  input  logic          flush,
  output logic          retire,
  output logic          illegal,
  output logic [CW-1:0] count,
  output logic          busy
`ifdef V_IQ_PERF_EN
  ,
  output logic [31:0]   stall_cycles,
  output logic [31:0]   retired_count
`endif
);

  localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  localparam logic [1:0] IDLE   = 2'd0;
  localparam logic [1:0] EXEC   = 2'd1;
  localparam logic [1:0] RETIRE = 2'd2;

  localparam logic [6:0] OP_V     = 7'b1010111;
  localparam logic [6:0] OP_LOADV = 7'b0000111;
  localparam logic [6:0] OP_STORV = 7'b0100111;

  logic [1:0]    state_q, state_d;
  logic [PW-1:0] wr_ptr_q, wr_ptr_d;
  logic [PW-1:0] rd_ptr_q, rd_ptr_d;
  logic [CW-1:0] count_q, count_d;
  logic          rdy_q, rdy_d;
  logic          illegal_q, illegal_d;
  logic [31:0]   issue_instr_q, issue_instr_d;
  logic [31:0]   issue_xreg_q, issue_xreg_d;
  logic [31:0]   instr_mem_q [DEPTH];
  logic [31:0]   instr_mem_d [DEPTH];
  logic [31:0]   xreg_mem_q  [DEPTH];
  logic [31:0]   xreg_mem_d  [DEPTH];

  logic [6:0] opcode;
  logic       legal_op;
  logic       accept;
  logic       push;
  logic       pop;
  logic       in_vcfg;

  function automatic logic [31:0] sat_inc(input logic [31:0] v);
    return (v == 32'hFFFF_FFFF) ? v : v + 32'd1;
  endfunction

  assign opcode   = iq.instr_in[6:0];
  assign legal_op = (opcode == OP_V) || (opcode == OP_LOADV) || (opcode == OP_STORV);
  assign accept   = iq.instr_valid && rdy_q;
  assign push     = accept && legal_op && !flush;
  // vsetvl* family retires after a single EXEC cycle without waiting on a unit
  assign in_vcfg  = (issue_instr_q[6:0] == OP_V) && (issue_instr_q[14:12] == 3'b111);

  always_comb begin
    state_d       = state_q;
    pop           = 1'b0;
    issue_instr_d = issue_instr_q;
    issue_xreg_d  = issue_xreg_q;
    case (state_q)
      IDLE: begin
        if (count_q != '0) begin
          pop     = 1'b1;
          state_d = EXEC;
        end
      end
      EXEC: begin
        if (in_vcfg || iq.unit_done) state_d = RETIRE;
      end
      RETIRE: begin
        if (count_q != '0) begin
          pop     = 1'b1;
          state_d = EXEC;
        end else begin
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
    if (flush) begin
      pop     = 1'b0;
      state_d = IDLE;
    end
    if (pop) begin
      issue_instr_d = instr_mem_q[rd_ptr_q];
      issue_xreg_d  = xreg_mem_q[rd_ptr_q];
    end
  end

  always_comb begin
    instr_mem_d = instr_mem_q;
    xreg_mem_d  = xreg_mem_q;
    wr_ptr_d    = wr_ptr_q;
    rd_ptr_d    = rd_ptr_q;
    count_d     = count_q;
    if (push) begin
      instr_mem_d[wr_ptr_q] = iq.instr_in;
      xreg_mem_d[wr_ptr_q]  = iq.xreg_in;
      wr_ptr_d              = wr_ptr_q + PW'(1);
    end
    if (pop) rd_ptr_d = rd_ptr_q + PW'(1);
    if (push && !pop)      count_d = count_q + CW'(1);
    else if (pop && !push) count_d = count_q - CW'(1);
    if (flush) begin
      wr_ptr_d = '0;
      rd_ptr_d = '0;
      count_d  = '0;
    end
    // Registered ready: a pop never frees a slot for the same edge
    rdy_d     = (count_d != CW'(DEPTH));
    illegal_d = accept && !legal_op && !flush;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q       <= IDLE;
      wr_ptr_q      <= '0;
      rd_ptr_q      <= '0;
      count_q       <= '0;
      rdy_q         <= 1'b0;
      illegal_q     <= 1'b0;
      issue_instr_q <= '0;
      issue_xreg_q  <= '0;
    end else begin
      state_q       <= state_d;
      wr_ptr_q      <= wr_ptr_d;
      rd_ptr_q      <= rd_ptr_d;
      count_q       <= count_d;
      rdy_q         <= rdy_d;
      illegal_q     <= illegal_d;
      issue_instr_q <= issue_instr_d;
      issue_xreg_q  <= issue_xreg_d;
    end
  end

  always_ff @(posedge clk) begin
    instr_mem_q <= instr_mem_d;
    xreg_mem_q  <= xreg_mem_d;
  end

  assign iq.instr_ready = rdy_q;
  assign iq.issue_instr = issue_instr_q;
  assign iq.issue_xreg  = issue_xreg_q;
  assign iq.issue_valid = (state_q == EXEC);
  assign retire         = (state_q == RETIRE);
  assign illegal        = illegal_q;
  assign count          = count_q;
  assign busy           = (state_q != IDLE) || (count_q != '0);

`ifdef V_IQ_PERF_EN
  logic [31:0] stall_cycles_q, stall_cycles_d;
  logic [31:0] retired_count_q, retired_count_d;

  always_comb begin
    stall_cycles_d  = stall_cycles_q;
    retired_count_d = retired_count_q;
    if (iq.instr_valid && !rdy_q) stall_cycles_d  = sat_inc(stall_cycles_q);
    if (state_q == RETIRE)        retired_count_d = sat_inc(retired_count_q);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      stall_cycles_q  <= '0;
      retired_count_q <= '0;
    end else begin
      stall_cycles_q  <= stall_cycles_d;
      retired_count_q <= retired_count_d;
    end
  end

  assign stall_cycles  = stall_cycles_q;
  assign retired_count = retired_count_q;
`endif

endmodule

// File: doc/v_issue_queue.md
Name: v_issue_queue

Overview:
- Instruction buffer and issue sequencer between the scalar base processor and the vector coprocessor top.
- Accepts 32-bit vector instructions with their scalar operand, queues them in a FIFO, and presents one at a time, held stable, on the coprocessor's instruction input.
- Waits for the execution unit's completion before retiring an instruction and issuing the next.

Parameters:
- DEPTH, 4, FIFO entries; power of two, minimum 2.
- CW, $clog2(DEPTH)+1, width of the occupancy count.

Ports:
- clk  in  1  clock.
- rst  in  1  reset, synchronous, active-high.
- instr_in  in  32  instruction from base processor.
- xreg_in  in  32  scalar rs1 value captured with the instruction.
- instr_valid  in  1  producer has an instruction.
- instr_ready  out  1  queue can accept.
- issue_instr  out  32  instruction to coprocessor (drives op_instr_base).
- issue_xreg  out  32  scalar operand to coprocessor (drives xreg_out).
- issue_valid  out  1  issue_instr/issue_xreg valid and held.
- unit_done  in  1  OR of the valu/vmul/vred/vsldu/vload done pulses.
- flush  in  1  discard queue and in-flight instruction.
- retire  out  1  one-cycle pulse per completed instruction.
- illegal  out  1  one-cycle pulse on an accepted non-vector opcode.
- count  out  CW  FIFO occupancy (excludes the in-flight instruction).
- busy  out  1  high when state != IDLE or count != 0.

Behaviour:
- Reset: all outputs 0 and FIFO empty while rst is high. instr_ready is 0 during rst and rises the cycle after rst falls. Reset mid-operation drops the in-flight instruction silently; no retire pulse.
- Enqueue: a handshake occurs when instr_valid && instr_ready on a rising edge.
  - instr_ready = !full.
  - No write-through: an enqueue while the FIFO is full is not accepted, even if a pop happens in the same cycle.
- Opcode filter on instr_in[6:0]:
  - 1010111 (OP-V), 0000111 (load-FP/vector load) and 0100111 (vector store) are enqueued.
  - Any other accepted opcode is dropped and illegal pulses the next cycle.
- vconfig: OP-V with funct3 [14:12] = 111.
- Pointers: wrap modulo DEPTH. count increments on push, decrements on pop, and is unchanged on simultaneous push and pop.
- FSM states: IDLE, EXEC, RETIRE.
  - IDLE: issue_valid = 0. If count != 0, pop the FIFO head into the issue registers and go to EXEC.
  - EXEC: issue_valid = 1; issue_instr and issue_xreg are held constant. A vconfig instruction stays exactly 1 cycle, then goes to RETIRE. Any other instruction stays until unit_done = 1 is sampled, then goes to RETIRE.
  - RETIRE: issue_valid = 0 (one mandatory bubble so writeback cannot double-write) and retire = 1. If count != 0, pop and go to EXEC; otherwise go to IDLE.
  - unit_done is ignored in IDLE and RETIRE.
- Latency:
  - Handshake at edge N into an empty, idle queue gives issue_valid = 1 from cycle N+2.
  - Back-to-back throughput is 1 instruction per (exec cycles + 1).
  - A vconfig instruction occupies 2 cycles.
- issue_instr and issue_xreg keep the last value when issue_valid = 0 (not zeroed), except after reset, when they are 0.
- flush:
  - Synchronous. Next cycle: FIFO empty, count = 0, state IDLE, issue_valid = 0, no retire pulse.
  - flush beats a same-cycle enqueue (the instruction is discarded) and a same-cycle unit_done.
  - rst beats flush.

Optional Feature:
- V_IQ_PERF_EN defined: adds the following outputs, all synchronously cleared by rst but not by flush.
  - stall_cycles (out 32): increments each cycle instr_valid && !instr_ready.
  - retired_count (out 32): increments on each retire pulse.
  - Both saturate at 32'hFFFFFFFF.
- V_IQ_PERF_EN undefined: these ports and counters do not exist; all other behaviour is identical.

Test Plan:
- Reset, then single vadd.vv (32'h022080D7) with xreg_in = 32'h5 at edge N -> issue_valid high from N+2 with issue_instr = 32'h022080D7 and issue_xreg = 5; unit_done at N+5 -> retire pulse at N+6, issue_valid low at N+6, busy low at N+7.
- vsetvli (32'h0C0072D7) followed by vadd -> vsetvli holds issue_valid for exactly 1 cycle with no unit_done needed; one bubble; vadd issues next.
- DEPTH = 4, hold unit_done = 0, push 6 instructions -> first goes in-flight, count reaches 4, instr_ready low and the 6th is held. Pulse unit_done -> retire, pop, and the 6th is accepted one cycle later; issue order matches push order.
- Push opcode 0110011 (scalar add) -> illegal pulse 1 cycle later, count stays 0, no issue.
- Flush in the same cycle as an enqueue while in EXEC with 2 queued -> next cycle count = 0, issue_valid = 0, no retire, flushed instructions never issue. Then assert rst mid-EXEC -> all outputs 0.
- With V_IQ_PERF_EN: fill queue and hold instr_valid for 3 blocked cycles -> stall_cycles = 3; after 5 completions retired_count = 5.
